// File: rtl/mu0_mem_pkg.sv
// rtl/mu0_mem_pkg.sv - shared FSM type and constants for the MU0 memory arbiter
package mu0_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX);

  // Out-of-range latencies are pulled into the supported window so the counter never wraps.
  function automatic int clamp_mem_lat(input int lat);
    if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mu0_mem_arbiter_if.sv
// rtl/mu0_mem_arbiter_if.sv - host, core-port and memory bus bundle of the MU0 memory arbiter
interface mu0_mem_arbiter_if
  import mu0_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_PORTS = 2
);
  logic                        host_en;
  logic                        host_req;
  logic                        host_rnw;
  logic [ADDR_W-1:0]           host_addr;
  logic [DATA_W-1:0]           host_wdata;
  logic [DATA_W-1:0]           host_rdata;
  logic                        host_ack;
  logic [N_PORTS-1:0]          req;
  logic [N_PORTS-1:0]          rnw;
  logic [N_PORTS*ADDR_W-1:0]   addr;
  logic [N_PORTS*DATA_W-1:0]   wdata;
  logic [N_PORTS-1:0]          ack;
  logic [DATA_W-1:0]           rdata;
  logic                        mem_rq;
  logic                        mem_rnw;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        busy;

  modport slave (
    input  host_en, host_req, host_rnw, host_addr, host_wdata,
    input  req, rnw, addr, wdata, mem_rdata,
    output host_rdata, host_ack, ack, rdata,
    output mem_rq, mem_rnw, mem_addr, mem_wdata, busy
  );

  modport master (
    output host_en, host_req, host_rnw, host_addr, host_wdata,
    output req, rnw, addr, wdata, mem_rdata,
    input  host_rdata, host_ack, ack, rdata,
    input  mem_rq, mem_rnw, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mu0_rr_arbiter.sv
// rtl/mu0_rr_arbiter.sv - combinational round-robin picker, search starts at i_ptr
module mu0_rr_arbiter #(
  parameter int N_PORTS = 2,
  parameter int IW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [N_PORTS-1:0] o_gnt,
  output logic [IW-1:0]      o_idx
);

  logic [IW:0] w_pos;
  logic        w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      // One extra bit so ptr+i can be folded back below N_PORTS for non-power-of-two counts.
      w_pos = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_pos >= (IW+1)'(N_PORTS)) w_pos = w_pos - (IW+1)'(N_PORTS);
      if (!w_found && i_req[w_pos[IW-1:0]]) begin
        w_found                = 1'b1;
        o_gnt[w_pos[IW-1:0]]   = 1'b1;
        o_idx                  = w_pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// rtl/mu0_mem_arbiter.sv - registered host/core arbiter in front of the single-ported MU0 memory
module mu0_mem_arbiter
  import mu0_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_PORTS = 2,
  parameter int MEM_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  mu0_mem_arbiter_if.slave bus
);

  localparam int IW  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int LAT = clamp_mem_lat(MEM_LAT);

  state_t               r_state;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic                 r_host_sel;
  logic [IW-1:0]        r_gnt_idx;
  logic [IW-1:0]        r_rr_ptr;
  logic                 r_rnw;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_mem_rq;
  logic [N_PORTS-1:0]   r_ack;
  logic                 r_host_ack;
  logic [DATA_W-1:0]    r_rdata;
  logic [DATA_W-1:0]    r_host_rdata;
  logic                 r_busy;

  logic [N_PORTS-1:0]   w_gnt;
  logic [IW-1:0]        w_idx;
  logic                 w_any;
  logic                 w_sel_rnw;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;

  mu0_rr_arbiter #(.N_PORTS(N_PORTS), .IW(IW)) u_rr (
    .i_req (bus.req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_any     = |w_gnt;
  assign w_sel_rnw = bus.rnw[w_idx];

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_idx == IW'(i)) begin
        w_sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_host_sel   <= 1'b0;
      r_gnt_idx    <= '0;
      r_rr_ptr     <= '0;
      r_rnw        <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_rq     <= 1'b0;
      r_ack        <= '0;
      r_host_ack   <= 1'b0;
      r_rdata      <= '0;
      r_host_rdata <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_mem_rq   <= 1'b0;
      r_ack      <= '0;
      r_host_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Payload is frozen here; later changes by the requester are ignored.
          if (bus.host_en && bus.host_req) begin
            r_host_sel <= 1'b1;
            r_rnw      <= bus.host_rnw;
            r_addr     <= bus.host_addr;
            r_wdata    <= bus.host_wdata;
            r_mem_rq   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_ISSUE;
          end else if (!bus.host_en && w_any) begin
            r_host_sel <= 1'b0;
            r_gnt_idx  <= w_idx;
            r_rnw      <= w_sel_rnw;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_mem_rq   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= LAT_CNT_W'(LAT - 1);
          r_state <= (LAT > 1) ? ST_WAIT : ST_DONE;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == LAT_CNT_W'(1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (r_rnw) begin
            if (r_host_sel) r_host_rdata <= bus.mem_rdata;
            else            r_rdata      <= bus.mem_rdata;
          end
          if (r_host_sel) begin
            r_host_ack <= 1'b1;
          end else begin
            r_ack[r_gnt_idx] <= 1'b1;
            r_rr_ptr         <= (r_gnt_idx == IW'(N_PORTS - 1)) ? '0 : r_gnt_idx + 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_rq     = r_mem_rq;
  assign bus.mem_rnw    = r_rnw;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.ack        = r_ack;
  assign bus.host_ack   = r_host_ack;
  assign bus.rdata      = r_rdata;
  assign bus.host_rdata = r_host_rdata;
  assign bus.busy       = r_busy;

endmodule
